// File: rtl/gray_key_counter_pkg.sv
// Shared definitions for the Gray-coded key counter.
//   key_state_e : 2-bit encoding of the per-key debounce FSM
//   KEY_UP      : index of the step-up key in iwv_keys
//   KEY_DOWN    : index of the step-down key in iwv_keys
package gray_key_counter_pkg;

    typedef enum logic [1:0] {
        StReleased   = 2'b00,
        StDebPress   = 2'b01,
        StPressed    = 2'b10,
        StDebRelease = 2'b11
    } key_state_e;

    localparam int unsigned KEY_UP   = 0;
    localparam int unsigned KEY_DOWN = 1;

endpackage

// File: rtl/gray_key_debounce.sv
// Per-key front end: two-flop synchronizer, optional debounce FSM and press-event generation.
// Configuration macro: GRAY_KEY_DEBOUNCE_EN (defined = debounce FSM, undefined = edge detect).
// Ports:
//   iw_clk    - clock
//   iw_rst_n  - asynchronous active-low reset
//   iw_key_n  - raw, asynchronous, active-low key
//   ow_press  - registered one-cycle press event
module gray_key_debounce #(
    parameter int unsigned p_DEBOUNCE_CYCLES = 1000000
) (
    input  logic iw_clk,
    input  logic iw_rst_n,
    input  logic iw_key_n,
    output logic ow_press
);
    import gray_key_counter_pkg::*;

    logic sync1_q, sync2_q;
    logic press_d, press_q;

    // Synchronizer resets to 1 so a key held through reset is not seen as already pressed.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync1_q <= iw_key_n;
            sync2_q <= sync1_q;
            press_q <= press_d;
        end
    end

    assign ow_press = press_q;

`ifdef GRAY_KEY_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(p_DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(p_DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    key_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt counts consecutive samples at the new level; the sample that leaves a
    // stable state is the first one, so the transition fires on the Nth sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (!sync2_q) begin
                    state_d = StDebPress;
                    cnt_d   = CntOne;
                end
            end
            StDebPress: begin
                if (sync2_q) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPressed: begin
                if (sync2_q) begin
                    state_d = StDebRelease;
                    cnt_d   = CntOne;
                end
            end
            StDebRelease: begin
                if (!sync2_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q <= StReleased;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic sync3_q;
    logic unused_cfg;

    assign unused_cfg = ^32'(p_DEBOUNCE_CYCLES);

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            sync3_q <= 1'b1;
        end else begin
            sync3_q <= sync2_q;
        end
    end

    // Falling edge of the synced key; registered, so the event is 3 cycles after the raw edge.
    always_comb begin
        press_d = sync3_q & ~sync2_q;
    end
`endif

endmodule

// File: rtl/gray_key_counter.sv
// Up/down binary counter driven by two push buttons, with registered Gray-code output.
// Configuration macro: GRAY_KEY_DEBOUNCE_EN enables the per-key debounce FSM.
// Ports:
//   iw_clk       - clock, rising edge
//   iw_rst_n     - asynchronous active-low reset
//   iwv_keys     - raw active-low keys, [0] step up, [1] step down
//   iw_load      - synchronous load strobe (highest priority)
//   iwv_load_val - binary value to load
//   owv_bin      - registered binary count
//   owv_gray     - registered Gray code of owv_bin
//   ow_step      - one-cycle pulse on any count update, including load
//   ow_wrap      - one-cycle pulse on modular wrap of an up/down step
module gray_key_counter #(
    parameter int unsigned p_WIDTH           = 10,
    parameter int unsigned p_DEBOUNCE_CYCLES = 1000000
) (
    input  logic               iw_clk,
    input  logic               iw_rst_n,
    input  logic [1:0]         iwv_keys,
    input  logic               iw_load,
    input  logic [p_WIDTH-1:0] iwv_load_val,
    output logic [p_WIDTH-1:0] owv_bin,
    output logic [p_WIDTH-1:0] owv_gray,
    output logic               ow_step,
    output logic               ow_wrap
);
    import gray_key_counter_pkg::*;

    localparam logic [p_WIDTH-1:0] One = p_WIDTH'(1);

    logic [1:0]         press;
    logic [p_WIDTH-1:0] bin_q, bin_d;
    logic [p_WIDTH-1:0] gray_q, gray_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;

    gray_key_debounce #(
        .p_DEBOUNCE_CYCLES(p_DEBOUNCE_CYCLES)
    ) u_key_up (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .iw_key_n (iwv_keys[KEY_UP]),
        .ow_press (press[KEY_UP])
    );

    gray_key_debounce #(
        .p_DEBOUNCE_CYCLES(p_DEBOUNCE_CYCLES)
    ) u_key_down (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .iw_key_n (iwv_keys[KEY_DOWN]),
        .ow_press (press[KEY_DOWN])
    );

    // Simultaneous up and down events cancel out.
    always_comb begin
        bin_d  = bin_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (iw_load) begin
            bin_d  = iwv_load_val;
            step_d = 1'b1;
        end else if (press[KEY_UP] ^ press[KEY_DOWN]) begin
            step_d = 1'b1;
            if (press[KEY_UP]) begin
                bin_d  = bin_q + One;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - One;
                wrap_d = ~|bin_q;
            end
        end
        // Gray is derived from the next binary value so both register on the same edge.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign owv_bin  = bin_q;
    assign owv_gray = gray_q;
    assign ow_step  = step_q;
    assign ow_wrap  = wrap_q;

endmodule

// File: tb/tb_gray_key_counter.sv
// Bench for gray_key_counter (p_WIDTH=4, p_DEBOUNCE_CYCLES=8), both macro builds.
module tb_gray_key_counter;

`ifdef GRAY_KEY_DEBOUNCE_EN
    localparam int Lat = 11;  // raw key edge -> ow_step, with 8-cycle debounce
`else
    localparam int Lat = 4;   // raw key edge -> event in 3 cycles, ow_step one later
`endif

    typedef struct packed {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] keys;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] ow_bin;
    logic [3:0] ow_gray;
    logic       ow_step;
    logic       ow_wrap;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] model;
    logic [3:0] prev_gray;
    logic       sweep;
    int         n_tests;
    int         n_fail;

    gray_key_counter #(
        .p_WIDTH          (4),
        .p_DEBOUNCE_CYCLES(8)
    ) dut (
        .iw_clk      (clk),
        .iw_rst_n    (rst_n),
        .iwv_keys    (keys),
        .iw_load     (load),
        .iwv_load_val(load_val),
        .owv_bin     (ow_bin),
        .owv_gray    (ow_gray),
        .ow_step     (ow_step),
        .ow_wrap     (ow_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] gray_dec(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [3:0] b, input logic w);
        sb.push_back('{bin: b, gray: gray4(b), wrap: w});
        model = b;
    endtask

    task automatic press_keys(input logic [1:0] mask);
        @(negedge clk);
        keys = keys & ~mask;
    endtask

    task automatic release_keys();
        @(negedge clk);
        keys = 2'b11;
        repeat (Lat + 4) @(negedge clk);
    endtask

    // Counts rising edges until ow_step, bounded.
    task automatic wait_step(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ow_step && n < 40);
        check(tag, n, exp_n);
    endtask

    task automatic do_load(input logic [3:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        push_exp(v, 1'b0);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic up_press(input string tag);
        push_exp(model + 4'd1, model == 4'hF);
        press_keys(2'b01);
        wait_step(tag, Lat);
        release_keys();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        keys      = 2'b11;
        load      = 1'b0;
        load_val  = '0;
        model     = '0;
        prev_gray = '0;
        sweep     = 1'b0;

        // Scoreboard monitor: every step must match the oldest pending expectation.
        fork
            forever begin
                @(posedge clk);
                #1;
                if (rst_n === 1'b1) begin
                    if (ow_step === 1'b1) begin
                        if (sb.size() == 0) begin
                            check("unexpected_step", 32'd1, 32'd0);
                        end else begin
                            mon_e = sb.pop_front();
                            check("step_bin", ow_bin, mon_e.bin);
                            check("step_gray", ow_gray, mon_e.gray);
                            check("step_wrap", ow_wrap, mon_e.wrap);
                            if (sweep) check("gray_onebit", $countones(ow_gray ^ prev_gray), 1);
                        end
                    end else begin
                        check("wrap_idle", ow_wrap, 1'b0);
                    end
                    check("gray_decode", gray_dec(ow_gray), ow_bin);
                    prev_gray = ow_gray;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_bin", ow_bin, 4'h0);
        check("rst_gray", ow_gray, 4'h0);
        check("rst_step", ow_step, 1'b0);
        check("rst_wrap", ow_wrap, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One clean up press held 20 cycles: one event only.
        push_exp(4'd1, 1'b0);
        press_keys(2'b01);
        wait_step("up_latency", Lat);
        repeat (20) @(negedge clk);
        release_keys();
        check("up_bin", ow_bin, 4'd1);
        check("up_gray", ow_gray, 4'b0001);

`ifdef GRAY_KEY_DEBOUNCE_EN
        // Bounce 0,1,0 at 3-cycle spacing, then held.
        push_exp(4'd2, 1'b0);
        @(negedge clk);
        keys[0] = 1'b0;
        repeat (3) @(negedge clk);
        keys[0] = 1'b1;
        repeat (3) @(negedge clk);
        keys[0] = 1'b0;
        wait_step("bounce_latency", Lat);
        release_keys();
        check("bounce_bin", ow_bin, 4'd2);
`endif

        // Wrap up from F, then wrap down from 0.
        do_load(4'hF);
        up_press("wrap_up_latency");
        check("wrap_up_bin", ow_bin, 4'h0);
        check("wrap_up_gray", ow_gray, 4'h0);
        push_exp(4'hF, 1'b1);
        press_keys(2'b10);
        wait_step("down_latency", Lat);
        release_keys();
        check("wrap_down_gray", ow_gray, 4'b1000);

        // Both keys pressed together: no step.
        press_keys(2'b11);
        repeat (Lat + 3) @(negedge clk);
        check("both_bin", ow_bin, 4'hF);
        release_keys();

        // Load in the same cycle as an up event: load wins, no wrap.
        @(negedge clk);
        keys[0] = 1'b0;
        repeat (Lat - 1) @(posedge clk);
        @(negedge clk);
        load     = 1'b1;
        load_val = 4'd5;
        push_exp(4'd5, 1'b0);
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("load_up_bin", ow_bin, 4'd5);
        release_keys();

        // Load of the current value still steps.
        do_load(4'd5);
        @(negedge clk);
        check("load_same_drained", sb.size(), 0);

        // Sweep 16 up presses.
        sweep = 1'b1;
        for (int i = 0; i < 16; i++) up_press("sweep_latency");
        sweep = 1'b0;
        check("sweep_bin", ow_bin, 4'd5);

        // Asynchronous reset clears outputs right after a load step.
        @(negedge clk);
        load     = 1'b1;
        load_val = 4'hA;
        push_exp(4'hA, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bin", ow_bin, 4'h0);
        check("arst_gray", ow_gray, 4'h0);
        check("arst_step", ow_step, 1'b0);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        model = '0;
        repeat (2) @(negedge clk);

`ifdef GRAY_KEY_DEBOUNCE_EN
        // Reset while DEB_PRESS count is 5 with the key held: re-qualified afterwards.
        do_load(4'd6);
        @(negedge clk);
        keys[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("deb_rst_bin", ow_bin, 4'h0);
        check("deb_rst_gray", ow_gray, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model = '0;
        push_exp(4'd1, 1'b0);
        wait_step("requal_latency", Lat);
        release_keys();
        check("requal_bin", ow_bin, 4'd1);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
